// File: rtl/rf_cmd_ctrl.sv
// Byte-command front end for a register file: decodes write (0xAA addr data) and
// read (0xBB addr) frames from a serial receiver and returns read data to a transmitter.
module rf_cmd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RD_TIMEOUT = 15
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid,
    input  logic                  TX_Busy,
    output logic [DATA_WIDTH-1:0] WrData,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic                  CMD_ERR,
    output logic [2:0]            dbg_state_o
);

    localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT + 1) : 1;
    localparam logic [DATA_WIDTH-1:0] CMD_WR = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD = DATA_WIDTH'(8'hBB);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        RD_WAIT = 3'd4,
        TX_SEND = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wrdata_q, wrdata_d;
    logic [DATA_WIDTH-1:0]   txdata_q, txdata_d;
    logic                    wren_q, wren_d;
    logic                    rden_q, rden_d;
    logic                    txvld_q, txvld_d;
    logic                    err_q, err_d;
    logic                    addr_ok;

    // An address byte is legal only if it fits the register file.
    assign addr_ok = ((RX_P_DATA >> ADDR_WIDTH) == '0);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wrdata_q <= '0;
            txdata_q <= '0;
            wren_q   <= 1'b0;
            rden_q   <= 1'b0;
            txvld_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wrdata_q <= wrdata_d;
            txdata_q <= txdata_d;
            wren_q   <= wren_d;
            rden_q   <= rden_d;
            txvld_q  <= txvld_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
        txdata_d = txdata_q;
        wren_d   = 1'b0;
        rden_d   = 1'b0;
        txvld_d  = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_WR) begin
                        state_d = WR_ADDR;
                    end else if (RX_P_DATA == CMD_RD) begin
                        state_d = RD_ADDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    if (addr_ok) begin
                        addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                        state_d = WR_DATA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    wrdata_d = RX_P_DATA;
                    wren_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    if (addr_ok) begin
                        addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                        rden_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = RD_WAIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            RD_WAIT: begin
                // A stray byte is flagged and dropped; the read keeps waiting.
                if (RX_D_VLD) begin
                    err_d = 1'b1;
                end
                if (RdData_Valid) begin
                    txdata_d = RdData;
                    cnt_d    = '0;
                    state_d  = TX_SEND;
                end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            TX_SEND: begin
                if (RX_D_VLD) begin
                    err_d = 1'b1;
                end
                if (!TX_Busy) begin
                    txvld_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign WrData      = wrdata_q;
    assign Address     = addr_q;
    assign WrEn        = wren_q;
    assign RdEn        = rden_q;
    assign TX_P_DATA   = txdata_q;
    assign TX_D_VLD    = txvld_q;
    assign CMD_ERR     = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// Bench for rf_cmd_ctrl: directed frames plus randomized frames checked against a
// register-file model and transaction queues.
module tb_rf_cmd_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int RT = 15;
    localparam logic [DW-1:0] CMD_WR = 8'hAA;
    localparam logic [DW-1:0] CMD_RD = 8'hBB;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [DW-1:0] RX_P_DATA = '0;
    logic          RX_D_VLD = 1'b0;
    logic [DW-1:0] RdData = '0;
    logic          RdData_Valid = 1'b0;
    logic          TX_Busy = 1'b0;
    logic [DW-1:0] WrData;
    logic [AW-1:0] Address;
    logic          WrEn;
    logic          RdEn;
    logic [DW-1:0] TX_P_DATA;
    logic          TX_D_VLD;
    logic          CMD_ERR;
    logic [2:0]    dbg_state;

    rf_cmd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_TIMEOUT(RT)) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RdData(RdData), .RdData_Valid(RdData_Valid), .TX_Busy(TX_Busy),
        .WrData(WrData), .Address(Address), .WrEn(WrEn), .RdEn(RdEn),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .CMD_ERR(CMD_ERR),
        .dbg_state_o(dbg_state)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    int err_exp = 0;
    int err_seen = 0;
    logic [DW-1:0]    mem_model [2**AW];
    logic [AW+DW-1:0] exp_wr_q[$];
    logic [AW-1:0]    exp_rd_q[$];
    logic [DW-1:0]    exp_tx_q[$];
    logic prev_wren = 1'b0, prev_rden = 1'b0, prev_txvld = 1'b0, prev_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [DW-1:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
    endtask

    // Transaction monitor: every observed write/read/transmit must match a queued expectation.
    always @(negedge CLK) begin : mon
        logic [AW+DW-1:0] e;
        if (RST) begin
            if (WrEn || RdEn) check("wr_rd_excl", 32'(WrEn && RdEn), 0);
            if (WrEn) begin
                check("wren_width", 32'(prev_wren), 0);
                if (exp_wr_q.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    e = exp_wr_q.pop_front();
                    check("wr_addr", 32'(Address), 32'(e[AW+DW-1:DW]));
                    check("wr_data", 32'(WrData), 32'(e[DW-1:0]));
                end
            end
            if (RdEn) begin
                check("rden_width", 32'(prev_rden), 0);
                if (exp_rd_q.size() == 0) check("rd_unexpected", 1, 0);
                else check("rd_addr", 32'(Address), 32'(exp_rd_q.pop_front()));
            end
            if (TX_D_VLD) begin
                check("txvld_width", 32'(prev_txvld), 0);
                check("tx_busy_gate", 32'(prev_busy), 0);
                if (exp_tx_q.size() == 0) check("tx_unexpected", 1, 0);
                else check("tx_byte", 32'(TX_P_DATA), 32'(exp_tx_q.pop_front()));
            end
            if (CMD_ERR) err_seen <= err_seen + 1;
            prev_wren  <= WrEn;
            prev_rden  <= RdEn;
            prev_txvld <= TX_D_VLD;
            prev_busy  <= TX_Busy;
        end else begin
            prev_wren  <= 1'b0;
            prev_rden  <= 1'b0;
            prev_txvld <= 1'b0;
            prev_busy  <= 1'b0;
        end
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_wr_q.push_back({a, d});
        mem_model[a] = d;
        send_byte(CMD_WR);
        send_byte(DW'(a));
        send_byte(d);
        check("wr_pulse", 32'(WrEn), 1);
        check("wr_no_rden", 32'(RdEn), 0);
        check("wr_addr_now", 32'(Address), 32'(a));
        check("wr_data_now", 32'(WrData), 32'(d));
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] r,
                           input int lat, input int busy, input bit inj);
        exp_rd_q.push_back(a);
        exp_tx_q.push_back(r);
        TX_Busy = (busy > 0);
        send_byte(CMD_RD);
        send_byte(DW'(a));
        check("rd_pulse", 32'(RdEn), 1);
        check("rd_no_wren", 32'(WrEn), 0);
        for (int i = 0; i < lat; i++) begin
            if (inj && i == 0) begin
                send_byte(8'h77);
                check("err_in_wait", 32'(CMD_ERR), 1);
                err_exp++;
            end else begin
                tick();
            end
        end
        RdData = r;
        RdData_Valid = 1'b1;
        tick();
        RdData_Valid = 1'b0;
        RdData = DW'($urandom);
        check("tx_capture", 32'(TX_P_DATA), 32'(r));
        check("tx_early", 32'(TX_D_VLD), 0);
        for (int i = 0; i < busy; i++) begin
            if (inj && i == 0) begin
                send_byte(8'h66);
                check("err_in_send", 32'(CMD_ERR), 1);
                err_exp++;
            end else begin
                tick();
            end
            check("tx_hold", 32'(TX_P_DATA), 32'(r));
            check("tx_blocked", 32'(TX_D_VLD), 0);
        end
        TX_Busy = 1'b0;
        tick();
        check("tx_vld", 32'(TX_D_VLD), 1);
        check("tx_data_out", 32'(TX_P_DATA), 32'(r));
    endtask

    task automatic do_timeout(input logic [AW-1:0] a);
        exp_rd_q.push_back(a);
        send_byte(CMD_RD);
        send_byte(DW'(a));
        for (int i = 0; i < RT - 1; i++) tick();
        check("to_not_yet", 32'(CMD_ERR), 0);
        tick();
        check("to_err", 32'(CMD_ERR), 1);
        err_exp++;
    endtask

    task automatic do_bad_cmd(input logic [DW-1:0] b);
        send_byte(b);
        check("badcmd_err", 32'(CMD_ERR), 1);
        err_exp++;
    endtask

    task automatic do_bad_addr(input bit is_rd, input logic [DW-1:0] b);
        send_byte(is_rd ? CMD_RD : CMD_WR);
        send_byte(b);
        check("badaddr_err", 32'(CMD_ERR), 1);
        check("badaddr_no_wr", 32'(WrEn), 0);
        check("badaddr_no_rd", 32'(RdEn), 0);
        err_exp++;
    endtask

    initial begin
        logic [DW-1:0] b;
        logic [AW-1:0] a;
        for (int i = 0; i < 2**AW; i++) mem_model[i] = '0;

        // Reset values
        repeat (2) @(posedge CLK);
        #1;
        check("rst_wrdata", 32'(WrData), 0);
        check("rst_addr", 32'(Address), 0);
        check("rst_txdata", 32'(TX_P_DATA), 0);
        check("rst_wren", 32'(WrEn), 0);
        check("rst_rden", 32'(RdEn), 0);
        check("rst_txvld", 32'(TX_D_VLD), 0);
        check("rst_err", 32'(CMD_ERR), 0);
        RST = 1'b1;
        tick();

        // Write frame, then values hold
        do_write(4'h5, 8'h3C);
        tick();
        check("wr_deassert", 32'(WrEn), 0);
        check("addr_hold", 32'(Address), 5);
        check("wrdata_hold", 32'(WrData), 8'h3C);

        // Read, no backpressure; then with 10 cycles of TX_Busy
        do_read(4'h2, 8'h81, 1, 0, 1'b0);
        tick();
        check("txvld_deassert", 32'(TX_D_VLD), 0);
        do_read(4'h2, 8'h81, 1, 10, 1'b0);

        // Error cases
        do_bad_cmd(8'h12);
        tick();
        check("err_deassert", 32'(CMD_ERR), 0);
        do_bad_addr(1'b0, 8'h15);
        do_timeout(4'h3);
        do_read(4'h9, 8'hE4, 3, 4, 1'b1);
        do_read(4'hF, 8'h5A, RT - 1, 0, 1'b0);

        // Reset in the middle of a write frame
        send_byte(CMD_WR);
        send_byte(8'h07);
        RST = 1'b0;
        #1;
        check("midrst_addr", 32'(Address), 0);
        check("midrst_wrdata", 32'(WrData), 0);
        check("midrst_txdata", 32'(TX_P_DATA), 0);
        check("midrst_wren", 32'(WrEn), 0);
        tick();
        tick();
        RST = 1'b1;
        do_write(4'h1, 8'h55);

        // Randomized frames against the register-file model
        for (int n = 0; n < 200; n++) begin
            a = AW'($urandom_range(0, 2**AW - 1));
            case ($urandom_range(0, 9))
                0, 1, 2: do_write(a, DW'($urandom));
                3, 4, 5: do_read(a, mem_model[a], $urandom_range(0, RT - 1),
                                 $urandom_range(0, 4), 1'($urandom_range(0, 1)));
                6: begin
                    b = DW'($urandom);
                    if (b == CMD_WR || b == CMD_RD) b = 8'h12;
                    do_bad_cmd(b);
                end
                7: do_bad_addr(1'($urandom_range(0, 1)),
                               {4'($urandom_range(1, 15)), 4'($urandom)});
                8: do_timeout(a);
                default: tick();
            endcase
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (4) tick();
        check("err_count", 32'(err_seen), 32'(err_exp));
        check("wr_q_empty", 32'(exp_wr_q.size()), 0);
        check("rd_q_empty", 32'(exp_rd_q.size()), 0);
        check("tx_q_empty", 32'(exp_tx_q.size()), 0);
        check("dbg_state_legal", 32'(dbg_state <= 3'd5), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_cmd_ctrl.md
RF_CMD_CTRL -- requirements
Module: rf_cmd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of command, data and read-back bytes.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, width of register-file address.
REQ-003 SHALL have parameter RD_TIMEOUT, default 15, maximum RD_WAIT cycles before abort.
REQ-004 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port RX_P_DATA  input  DATA_WIDTH  received byte from serial receiver.
REQ-007 SHALL have port RX_D_VLD  input  1  one-cycle strobe; RX_P_DATA valid this cycle.
REQ-008 SHALL have port RdData  input  DATA_WIDTH  register-file read data.
REQ-009 SHALL have port RdData_Valid  input  1  register-file read-data qualifier.
REQ-010 SHALL have port TX_Busy  input  1  transmitter busy; high blocks TX_D_VLD.
REQ-011 SHALL have port WrData  output  DATA_WIDTH  register-file write data.
REQ-012 SHALL have port Address  output  ADDR_WIDTH  register-file address.
REQ-013 SHALL have port WrEn  output  1  register-file write enable.
REQ-014 SHALL have port RdEn  output  1  register-file read enable.
REQ-015 SHALL have port TX_P_DATA  output  DATA_WIDTH  byte to transmitter.
REQ-016 SHALL have port TX_D_VLD  output  1  one-cycle transmit request.
REQ-017 SHALL have port CMD_ERR  output  1  one-cycle protocol-error pulse.

Function
REQ-018 SHALL implement FSM states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND; all outputs registered.
REQ-019 SHALL, in IDLE with RX_D_VLD, go to WR_ADDR on 0xAA, RD_ADDR on 0xBB; any other byte pulses CMD_ERR next cycle and stays IDLE.
REQ-020 SHALL, in WR_ADDR/RD_ADDR with RX_D_VLD, latch RX_P_DATA[ADDR_WIDTH-1:0] into Address if bits [DATA_WIDTH-1:ADDR_WIDTH] are zero; otherwise pulse CMD_ERR, return IDLE, issue no access.
REQ-021 SHALL go WR_ADDR -> WR_DATA on a valid address byte.
REQ-022 SHALL, in WR_DATA with RX_D_VLD, drive WrData=RX_P_DATA and WrEn=1 for exactly the next cycle, then return IDLE.
REQ-023 SHALL go RD_ADDR -> RD_WAIT on a valid address byte, with RdEn=1 for exactly the next cycle.
REQ-024 SHALL, in RD_WAIT, on RdData_Valid capture RdData into TX_P_DATA and go TX_SEND.
REQ-025 SHALL count RD_WAIT cycles; at RD_TIMEOUT with no RdData_Valid, pulse CMD_ERR and return IDLE.
REQ-026 SHALL, in TX_SEND, hold TX_P_DATA stable, wait while TX_Busy=1, then drive TX_D_VLD=1 for one cycle and return IDLE.
REQ-027 SHALL pulse CMD_ERR on RX_D_VLD during RD_WAIT or TX_SEND, discard the byte, and remain in the current state.
REQ-028 SHALL never assert WrEn and RdEn in the same cycle; both default 0 outside their one-cycle pulses.
REQ-029 SHALL hold Address and WrData at last values between accesses.
REQ-030 SHALL accept back-to-back frames: the first byte of the next frame is accepted the cycle after returning to IDLE.

Reset
REQ-031 SHALL, on RST low at any time including mid-frame, force IDLE, clear the timeout counter, and set WrData, Address, TX_P_DATA to 0 and WrEn, RdEn, TX_D_VLD, CMD_ERR to 0.
REQ-032 SHALL resume normal operation on the first rising CLK edge after RST deasserts.

Verification
REQ-033 SHALL verify write: bytes 0xAA, 0x05, 0x3C -> one-cycle WrEn with Address=5, WrData=0x3C; RdEn stays 0.
REQ-034 SHALL verify read: 0xBB, 0x02, RdData=0x81 with RdData_Valid one cycle after RdEn, TX_Busy=0 -> TX_P_DATA=0x81, single TX_D_VLD pulse.
REQ-035 SHALL verify TX backpressure: read as above with TX_Busy=1 for 10 cycles -> TX_D_VLD only after TX_Busy falls, TX_P_DATA stable throughout.
REQ-036 SHALL verify errors: byte 0x12 in IDLE -> CMD_ERR pulse; 0xAA, 0x15 -> CMD_ERR, no WrEn; RdData_Valid withheld 15 cycles -> CMD_ERR, IDLE.
REQ-037 SHALL verify reset mid-frame: RST low after 0xAA, 0x07 -> no WrEn; a subsequent 0xAA, 0x01, 0x55 frame writes normally.
